epl_read_mux_buf: RTL and testbench
===================================

# epl_read_mux_buf

Parametrised read-data column mux with an output buffer for the EPLFFRAM02 macro read path. It selects one `TWORD_WIDTH`-bit word out of a `TWORD_WIDTH*MUX`-bit sense-amp column bus using a one-hot column select, for any `MUX` ratio. The selected word is pushed into a `DEPTH`-entry FIFO, so the core read strobe is decoupled from a back-pressuring downstream consumer (bus interface or BIST comparator).

## Interface
Parameters:
- `TWORD_WIDTH`, default 16: output word width.
- `MUX`, default 2: column mux ratio; legal values 2, 4, 8.
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.

Ports:
- `pClk_i` in 1: clock.
- `nRst_i` in 1: reset, asynchronous, active-low.
- `pDto_i` in `TWORD_WIDTH*MUX`: column data; bit `idx*MUX+k` belongs to word bit `idx`, column `k`.
- `pAcy_i` in `MUX`: one-hot column select; bit `k` selects column `k`.
- `pRead01_i` in 1: read strobe; `pDto_i` and `pAcy_i` are valid this cycle.
- `pReady_i` in 1: downstream accepts the head word this cycle.
- `pDo_o` out `TWORD_WIDTH`: head word; zero when FIFO empty.
- `pRead1_o` out 1: head valid (FIFO not empty).
- `pSelErr_o` out 1: head word was read with a non-one-hot `pAcy_i`.
- `pBusy_o` out 1: FIFO full (count == `DEPTH`).
- `pOvf_o` out 1: sticky overflow flag.

## Operation
- Mux (combinational):
  - If `pAcy_i` is one-hot with bit `k` set, word bit `idx` = `pDto_i[idx*MUX+k]`.
  - If `pAcy_i` is zero or has more than one bit set, the word is all zeros and its error bit = 1.
- Push: `pRead01_i` high pushes {word, error bit}, subject to the full rule below.
- Pop: `pRead1_o & pReady_i` pops the head.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. Count is `$clog2(DEPTH)+1` bits, range 0..`DEPTH`.
- Simultaneous push and pop:
  - Not full: count unchanged, both pointers advance.
  - Full: push is accepted because the pop frees the slot.
  - Empty: push only. Data appears next cycle; no same-cycle bypass.
- Overflow: push while full and `pReady_i` low:
  - the word is dropped;
  - FIFO contents are unchanged;
  - `pOvf_o` is set and holds until reset.
- `pReady_i` while empty is ignored.
- Reset, including mid-burst: pointers, count and storage cleared; in-flight words discarded.
  - `pDo_o` = 0, `pRead1_o` = 0, `pSelErr_o` = 0, `pBusy_o` = 0, `pOvf_o` = 0.

## Timing
- Read latency is 1 cycle. A strobe at edge N into an empty FIFO gives `pRead1_o` = 1 and valid `pDo_o` after edge N.
- Sustained throughput is 1 word/cycle when `pReady_i` is held high.
- All outputs are registered or decoded from registers only. There is no combinational path from `pReady_i` or `pRead01_i` to any output.
- `pBusy_o` reflects the count after the previous edge. Upstream must not strobe while `pBusy_o` = 1 unless it knows `pReady_i` = 1 in that cycle.
- `pDo_o`, `pSelErr_o` and `pRead1_o` change together after the same edge.

## Configuration
- `EPL_RDMUX_PARITY_EN` defined:
  - adds output port `pDoPar_o` (1 bit), the even parity (XOR-reduce) of the selected word;
  - parity is computed at push time and stored per entry;
  - `pDoPar_o` is 0 when empty and after reset.
- Not defined: the port and its storage are absent; all other behaviour is identical.

## Structure
- Shared spec header `EPLFFRAM02_spec.vh` holds:
  - defaults `TWORD_WIDTH`, `MUX`, `DEPTH`;
  - a legal-`MUX` check macro;
  - the `EPL_RDMUX_PARITY_EN` default (undefined).
- Sub-module `epl_rdmux_fifo`:
  - generic synchronous FIFO of width `TWORD_WIDTH+1` (+1 with parity) and depth `DEPTH`;
  - provides push/pop, full/empty, overflow.
- The top level holds the mux, the one-hot check and the output zeroing.

## Test plan
- MUX=2, `pDto_i`=32'hAAAA_5555:
  - `pAcy_i`=01 → `pDo_o`=16'h00FF, `pSelErr_o`=0, one cycle after the strobe;
  - `pAcy_i`=10 → `pDo_o`=16'hFF00.
- MUX=4, `pAcy_i`=0100 with column-2 bits set to 16'h1234 → `pDo_o`=16'h1234. `pAcy_i`=0110 → `pDo_o`=0, `pSelErr_o`=1.
- DEPTH=2, `pReady_i`=0, three strobes (A, B, C):
  - `pBusy_o`=1 after the second strobe;
  - C is dropped and `pOvf_o`=1 sticky;
  - then `pReady_i`=1 → outputs A, then B, then `pRead1_o`=0.
- Full FIFO, strobe D with `pReady_i`=1 in the same cycle → no overflow; subsequent outputs B, D.
- `nRst_i` asserted mid-burst with 2 words queued → all outputs 0 immediately; next strobe E appears alone one cycle later.
- With `EPL_RDMUX_PARITY_EN`, word 16'h0007 → `pDoPar_o`=1; word 16'h0003 → `pDoPar_o`=0.

Source files
------------

// File: rtl/epl_read_mux_buf_pkg.sv
// Shared constants and helpers for the EPLFFRAM02 read-data mux and output buffer.
// Parity build option: EPL_RDMUX_PARITY_EN (undefined by default).
package epl_read_mux_buf_pkg;

  localparam int DEF_TWORD_WIDTH = 16;
  localparam int DEF_MUX         = 2;
  localparam int DEF_DEPTH       = 2;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_e;

  function automatic bit mux_legal(input int m);
    return (m == 2) || (m == 4) || (m == 8);
  endfunction

  function automatic bit depth_legal(input int d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/epl_rdmux_fifo.sv
// Generic synchronous FIFO for the read path: drop-on-full with sticky overflow,
// a pop frees the slot for a same-cycle push, and the head reads as zero when empty.
module epl_rdmux_fifo
  import epl_read_mux_buf_pkg::*;
#(
  parameter int WIDTH = DEF_TWORD_WIDTH + 1,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             pClk_i,
  input  logic             nRst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_req,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mem [DEPTH];
  fifo_state_e      state;
  logic             pop;
  logic             push_ok;
  logic             drop;

  always_comb begin
    state = FIFO_PARTIAL;
    if (count == '0) begin
      state = FIFO_EMPTY;
    end else if (count == FULL_CNT) begin
      state = FIFO_FULL;
    end
  end

  assign valid = (state != FIFO_EMPTY);
  assign full  = (state == FIFO_FULL);
  assign head  = valid ? mem[rd_ptr] : '0;

  // When full, a pop in the same cycle vacates the slot the write pointer aims at.
  assign pop     = pop_req & valid;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge pClk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/epl_read_mux_buf.sv
// EPLFFRAM02 read path: one-hot column mux feeding a small output FIFO.
// Define EPL_RDMUX_PARITY_EN to add the stored per-word parity output pDoPar_o.
module epl_read_mux_buf
  import epl_read_mux_buf_pkg::*;
#(
  parameter int TWORD_WIDTH = DEF_TWORD_WIDTH,
  parameter int MUX         = DEF_MUX,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                       pClk_i,
  input  logic                       nRst_i,
  input  logic [TWORD_WIDTH*MUX-1:0] pDto_i,
  input  logic [MUX-1:0]             pAcy_i,
  input  logic                       pRead01_i,
  input  logic                       pReady_i,
  output logic [TWORD_WIDTH-1:0]     pDo_o,
  output logic                       pRead1_o,
  output logic                       pSelErr_o,
  output logic                       pBusy_o,
  output logic                       pOvf_o
`ifdef EPL_RDMUX_PARITY_EN
  ,
  output logic                       pDoPar_o
`endif
);

  if (!mux_legal(MUX)) begin : g_bad_mux
    $error("epl_read_mux_buf: MUX must be 2, 4 or 8");
  end
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("epl_read_mux_buf: DEPTH must be a power of two >= 2");
  end

`ifdef EPL_RDMUX_PARITY_EN
  localparam int FW = TWORD_WIDTH + 2;
`else
  localparam int FW = TWORD_WIDTH + 1;
`endif

  logic                   sel_onehot;
  logic                   sel_err;
  logic [TWORD_WIDTH-1:0] word;
  logic [FW-1:0]          din;
  logic [FW-1:0]          head;
  logic                   valid;
  logic                   full;
  logic                   ovf;

  assign sel_onehot = (pAcy_i != '0) && ((pAcy_i & (pAcy_i - 1'b1)) == '0);
  assign sel_err    = ~sel_onehot;

  // With a one-hot select the AND-OR picks exactly one column; otherwise force zero.
  always_comb begin
    word = '0;
    for (int idx = 0; idx < TWORD_WIDTH; idx++) begin
      word[idx] = sel_onehot & (|(pDto_i[idx*MUX +: MUX] & pAcy_i));
    end
  end

`ifdef EPL_RDMUX_PARITY_EN
  assign din = {^word, sel_err, word};
`else
  assign din = {sel_err, word};
`endif

  epl_rdmux_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .pClk_i  (pClk_i),
    .nRst_i  (nRst_i),
    .push    (pRead01_i),
    .din     (din),
    .pop_req (pReady_i),
    .head    (head),
    .valid   (valid),
    .full    (full),
    .ovf     (ovf)
  );

  assign pDo_o     = head[TWORD_WIDTH-1:0];
  assign pSelErr_o = head[TWORD_WIDTH];
  assign pRead1_o  = valid;
  assign pBusy_o   = full;
  assign pOvf_o    = ovf;
`ifdef EPL_RDMUX_PARITY_EN
  assign pDoPar_o  = head[TWORD_WIDTH+1];
`endif

endmodule

// File: tb/tb_epl_read_mux_buf.sv
// Directed self-checking bench for epl_read_mux_buf (MUX=2 and MUX=4 instances).
// Parity checks are compiled in when EPL_RDMUX_PARITY_EN is defined.
module tb_epl_read_mux_buf;

  logic        clk;
  logic        nrst;
  logic [31:0] dto2;
  logic [1:0]  acy2;
  logic        rd2, rdy2;
  logic [15:0] do2;
  logic        v2, err2, busy2, ovf2;
  logic [63:0] dto4;
  logic [3:0]  acy4;
  logic        rd4, rdy4;
  logic [15:0] do4;
  logic        v4, err4, busy4, ovf4;
`ifdef EPL_RDMUX_PARITY_EN
  logic        par2, par4;
`endif

  int checks = 0;
  int errors = 0;

  epl_read_mux_buf #(.TWORD_WIDTH(16), .MUX(2), .DEPTH(2)) dut (
    .pClk_i(clk), .nRst_i(nrst), .pDto_i(dto2), .pAcy_i(acy2),
    .pRead01_i(rd2), .pReady_i(rdy2), .pDo_o(do2), .pRead1_o(v2),
    .pSelErr_o(err2), .pBusy_o(busy2), .pOvf_o(ovf2)
`ifdef EPL_RDMUX_PARITY_EN
    , .pDoPar_o(par2)
`endif
  );

  epl_read_mux_buf #(.TWORD_WIDTH(16), .MUX(4), .DEPTH(2)) dut4 (
    .pClk_i(clk), .nRst_i(nrst), .pDto_i(dto4), .pAcy_i(acy4),
    .pRead01_i(rd4), .pReady_i(rdy4), .pDo_o(do4), .pRead1_o(v4),
    .pSelErr_o(err4), .pBusy_o(busy4), .pOvf_o(ovf4)
`ifdef EPL_RDMUX_PARITY_EN
    , .pDoPar_o(par4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bus2(input logic [15:0] w);
    logic [31:0] b;
    b = 32'hAAAA_AAAA;
    for (int i = 0; i < 16; i++) b[2*i] = w[i];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b1; dto2 = '0; acy2 = '0; rd2 = 0; rdy2 = 0;
    dto4 = '0; acy4 = '0; rd4 = 0; rdy4 = 0;
    #1 nrst = 1'b0;
    tick();
    checks++; if ({do2, v2, err2, busy2, ovf2} !== 20'h0) begin errors++; $display("[TB] FAIL reset_dut2 got %h want 0", {do2, v2, err2, busy2, ovf2}); end
    checks++; if ({do4, v4, err4, busy4, ovf4} !== 20'h0) begin errors++; $display("[TB] FAIL reset_dut4 got %h want 0", {do4, v4, err4, busy4, ovf4}); end
    nrst = 1'b1;
  endtask

  task automatic test_mux2();
    rdy2 = 1; dto2 = 32'hAAAA_5555; acy2 = 2'b01; rd2 = 1;
    checks++; if (v2 !== 1'b0) begin errors++; $display("[TB] FAIL mux2_no_bypass got %b want 0", v2); end
    tick();
    checks++; if ({v2, err2, do2} !== {2'b10, 16'h00FF}) begin errors++; $display("[TB] FAIL mux2_col0 got v=%b e=%b d=%h want 1 0 00ff", v2, err2, do2); end
    acy2 = 2'b10;
    tick();
    checks++; if ({v2, err2, busy2, do2} !== {3'b100, 16'hFF00}) begin errors++; $display("[TB] FAIL mux2_col1 got v=%b e=%b b=%b d=%h want 1 0 0 ff00", v2, err2, busy2, do2); end
    acy2 = 2'b00;
    tick();
    checks++; if ({v2, err2, do2} !== {2'b11, 16'h0000}) begin errors++; $display("[TB] FAIL mux2_zero_sel got v=%b e=%b d=%h want 1 1 0000", v2, err2, do2); end
    rd2 = 0;
    tick();
    checks++; if ({v2, err2, do2} !== 18'h0) begin errors++; $display("[TB] FAIL mux2_drain got v=%b e=%b d=%h want 0 0 0000", v2, err2, do2); end
  endtask

  task automatic test_mux4();
    logic [15:0] c0, c1, c2, c3;
    c0 = 16'h8421; c1 = 16'hFFFF; c2 = 16'h1234; c3 = 16'hAAAA;
    for (int i = 0; i < 16; i++) begin
      dto4[4*i]   = c0[i];
      dto4[4*i+1] = c1[i];
      dto4[4*i+2] = c2[i];
      dto4[4*i+3] = c3[i];
    end
    rdy4 = 1; acy4 = 4'b0100; rd4 = 1;
    tick();
    checks++; if ({v4, err4, do4} !== {2'b10, 16'h1234}) begin errors++; $display("[TB] FAIL mux4_col2 got v=%b e=%b d=%h want 1 0 1234", v4, err4, do4); end
    acy4 = 4'b0110;
    tick();
    checks++; if ({v4, err4, do4} !== {2'b11, 16'h0000}) begin errors++; $display("[TB] FAIL mux4_multi got v=%b e=%b d=%h want 1 1 0000", v4, err4, do4); end
    acy4 = 4'b1000;
    tick();
    checks++; if ({v4, err4, do4} !== {2'b10, 16'hAAAA}) begin errors++; $display("[TB] FAIL mux4_col3 got v=%b e=%b d=%h want 1 0 aaaa", v4, err4, do4); end
    rd4 = 0;
    tick();
    checks++; if (v4 !== 1'b0) begin errors++; $display("[TB] FAIL mux4_drain got %b want 0", v4); end
  endtask

  task automatic test_overflow();
    rdy2 = 0; acy2 = 2'b01; rd2 = 1; dto2 = bus2(16'h00A1);
    tick();
    checks++; if ({v2, busy2, do2} !== {2'b10, 16'h00A1}) begin errors++; $display("[TB] FAIL ovf_first got v=%b b=%b d=%h want 1 0 00a1", v2, busy2, do2); end
    dto2 = bus2(16'h00B2);
    tick();
    checks++; if ({busy2, ovf2} !== 2'b10) begin errors++; $display("[TB] FAIL ovf_full got b=%b o=%b want 1 0", busy2, ovf2); end
    dto2 = bus2(16'h00C3);
    tick();
    checks++; if ({ovf2, busy2, do2} !== {2'b11, 16'h00A1}) begin errors++; $display("[TB] FAIL ovf_drop got o=%b b=%b d=%h want 1 1 00a1", ovf2, busy2, do2); end
    rd2 = 0; rdy2 = 1;
    tick();
    checks++; if ({v2, ovf2, busy2, do2} !== {3'b110, 16'h00B2}) begin errors++; $display("[TB] FAIL ovf_second got v=%b o=%b b=%b d=%h want 1 1 0 00b2", v2, ovf2, busy2, do2); end
    tick();
    checks++; if ({v2, ovf2, do2} !== {2'b01, 16'h0000}) begin errors++; $display("[TB] FAIL ovf_empty got v=%b o=%b d=%h want 0 1 0000", v2, ovf2, do2); end
  endtask

  task automatic test_full_push_pop();
    pulse_reset();
    checks++; if (ovf2 !== 1'b0) begin errors++; $display("[TB] FAIL fpp_ovf_clear got %b want 0", ovf2); end
    rdy2 = 0; acy2 = 2'b01; rd2 = 1; dto2 = bus2(16'h0A0A);
    tick();
    dto2 = bus2(16'h0B0B);
    tick();
    dto2 = bus2(16'h0D0D); rdy2 = 1;
    tick();
    checks++; if ({ovf2, busy2, do2} !== {2'b01, 16'h0B0B}) begin errors++; $display("[TB] FAIL fpp_swap got o=%b b=%b d=%h want 0 1 0b0b", ovf2, busy2, do2); end
    rd2 = 0;
    tick();
    checks++; if ({v2, busy2, do2} !== {2'b10, 16'h0D0D}) begin errors++; $display("[TB] FAIL fpp_d got v=%b b=%b d=%h want 1 0 0d0d", v2, busy2, do2); end
    tick();
    checks++; if ({v2, ovf2} !== 2'b00) begin errors++; $display("[TB] FAIL fpp_empty got v=%b o=%b want 0 0", v2, ovf2); end
  endtask

  task automatic test_reset_midburst();
    rdy2 = 0; acy2 = 2'b01; rd2 = 1; dto2 = bus2(16'h1111);
    tick();
    dto2 = bus2(16'h2222);
    tick();
    rd2 = 0;
    nrst = 1'b0;
    #1;
    checks++; if ({do2, v2, err2, busy2, ovf2} !== 20'h0) begin errors++; $display("[TB] FAIL midrst_zero got %h want 0", {do2, v2, err2, busy2, ovf2}); end
    nrst = 1'b1;
    rd2 = 1; dto2 = bus2(16'hEEEE);
    tick();
    checks++; if ({v2, busy2, do2} !== {2'b10, 16'hEEEE}) begin errors++; $display("[TB] FAIL midrst_e got v=%b b=%b d=%h want 1 0 eeee", v2, busy2, do2); end
    rd2 = 0; rdy2 = 1;
    tick();
    checks++; if ({v2, do2} !== 17'h0) begin errors++; $display("[TB] FAIL midrst_alone got v=%b d=%h want 0 0000", v2, do2); end
  endtask

`ifdef EPL_RDMUX_PARITY_EN
  task automatic test_parity();
    pulse_reset();
    checks++; if (par2 !== 1'b0) begin errors++; $display("[TB] FAIL par_reset got %b want 0", par2); end
    rdy2 = 1; acy2 = 2'b01; rd2 = 1; dto2 = bus2(16'h0007);
    tick();
    checks++; if (par2 !== 1'b1) begin errors++; $display("[TB] FAIL par_0007 got %b want 1", par2); end
    dto2 = bus2(16'h0003);
    tick();
    checks++; if (par2 !== 1'b0) begin errors++; $display("[TB] FAIL par_0003 got %b want 0", par2); end
    dto2 = bus2(16'h0001);
    tick();
    checks++; if (par2 !== 1'b1) begin errors++; $display("[TB] FAIL par_0001 got %b want 1", par2); end
    rd2 = 0;
    tick();
    checks++; if (par2 !== 1'b0) begin errors++; $display("[TB] FAIL par_empty got %b want 0", par2); end
  endtask
`endif

  initial begin
    test_reset();
    test_mux2();
    test_mux4();
    test_overflow();
    test_full_push_pop();
    test_reset_midburst();
`ifdef EPL_RDMUX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
